// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - MEM stage with req/ready SRAM handshake, watchdog and MEM/WB register
// Stalls the pipeline while a data access is outstanding and aborts it after TIMEOUT idle cycles.
module mem_stage_sram #(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PC,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [31:0]       alu_res_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       data_mem_out,
  output logic              mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              err_q;

  logic [31:0]       pc_q, pc_d;
  logic              wb_en_q, wb_en_d;
  logic              r_en_q, r_en_d;
  logic [31:0]       alu_q, alu_d;
  logic [3:0]        dest_q, dest_d;

  logic              acc;
  logic              at_limit;
  logic              freeze_w;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] addr_d;

  assign acc      = mem_r_en_in | mem_w_en_in;
  assign at_limit = (cnt_q == CNT_MAX);
  assign freeze_w = ((state_q == IDLE) & acc) |
                    ((state_q == BUSY) & ~mem_ready & ~at_limit);

  // Underflow below ADDR_BASE wraps modulo 2^32 on purpose.
  assign offset = alu_res_in - ADDR_BASE;
  assign addr_d = ADDR_W'(offset >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            we_q    <= mem_w_en_in;
            addr_q  <= addr_d;
            wdata_q <= val_rm_in;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            req_q   <= 1'b0;
            data_q  <= mem_rdata;
            state_q <= IDLE;
          end else if (at_limit) begin
            // Abandon the access; the instruction still retires with zero data.
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            data_q  <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    wb_en_d = 1'b0;
    r_en_d  = 1'b0;
    alu_d   = alu_q;
    dest_d  = dest_q;
    if (!freeze_w) begin
      pc_d    = PC_in;
      wb_en_d = wb_en_in;
      r_en_d  = mem_r_en_in;
      alu_d   = alu_res_in;
      dest_d  = dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      wb_en_q <= 1'b0;
      r_en_q  <= 1'b0;
      alu_q   <= '0;
      dest_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      wb_en_q <= wb_en_d;
      r_en_q  <= r_en_d;
      alu_q   <= alu_d;
      dest_q  <= dest_d;
    end
  end

  assign freeze       = freeze_w;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign PC           = pc_q;
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = r_en_q;
  assign alu_res_out  = alu_q;
  assign dest_out     = dest_q;
  assign data_mem_out = data_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - randomized instruction-level check of mem_stage_sram
module tb_mem_stage_sram;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, alu_res_in, val_rm_in, mem_rdata;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, mem_ready;
  logic [3:0]  dest_in;
  logic        freeze, mem_req, mem_we, wb_en_out, mem_r_en_out, mem_err;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, PC, alu_res_out, data_mem_out;
  logic [3:0]  dest_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_data;
  logic        exp_err;

  mem_stage_sram #(.ADDR_BASE(1024), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PC(PC), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out),
    .data_mem_out(data_mem_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dest);
    PC_in = pc; wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_rm_in = rm; dest_in = dest;
  endtask

  // Presents one instruction at the current cycle and retires it; memory answers after k
  // wait cycles, or never when stuck is set.
  task automatic do_instr(input logic [31:0] pc, input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dest,
                          input int k, input bit stuck, input logic [31:0] rdat);
    int fz;
    int lat;
    bit stable;
    logic [31:0] exp_addr;
    set_in(pc, wb, r, w, alu, rm, dest);
    if (!(r | w)) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      check("alu_freeze", freeze, 0);
      step();
      mem_ready = 1'b0;
      check("alu_pc", PC, pc);
      check("alu_wb", wb_en_out, wb);
      check("alu_ren", mem_r_en_out, 0);
      check("alu_res", alu_res_out, alu);
      check("alu_dest", dest_out, dest);
      check("alu_data_hold", data_mem_out, exp_data);
      check("alu_req", mem_req, 0);
      check("alu_err", mem_err, exp_err);
    end else begin
      exp_addr = ((alu - 32'd1024) >> 2) & 32'h0000FFFF;
      mem_ready = 1'b0;
      fz = 0;
      stable = 1'b1;
      @(negedge clk);
      if (freeze) fz++;
      step();
      check("req_up", mem_req, 1);
      check("req_we", mem_we, w);
      check("req_addr", mem_addr, exp_addr);
      check("req_wdata", mem_wdata, w ? rm : mem_wdata);
      check("bubble_wb", wb_en_out, 0);
      check("bubble_ren", mem_r_en_out, 0);
      lat = stuck ? TO : k;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (freeze) fz++;
        if (mem_req !== 1'b1 || mem_addr !== exp_addr[15:0] || mem_we !== w ||
            (w && mem_wdata !== rm) || wb_en_out !== 1'b0)
          stable = 1'b0;
        step();
      end
      if (!stuck) begin
        mem_ready = 1'b1;
        mem_rdata = rdat;
      end
      @(negedge clk);
      if (freeze) fz++;
      step();
      mem_ready = 1'b0;
      if (stuck) begin
        exp_data = 32'h0;
        exp_err  = 1'b1;
      end else begin
        exp_data = rdat;
      end
      check("freeze_cycles", fz, lat + 1);
      check("req_stable", stable, 1);
      check("req_down", mem_req, 0);
      check("mem_pc", PC, pc);
      check("mem_wb", wb_en_out, wb);
      check("mem_ren", mem_r_en_out, r);
      check("mem_res", alu_res_out, alu);
      check("mem_dest", dest_out, dest);
      check("mem_data", data_mem_out, exp_data);
      check("mem_err", mem_err, exp_err);
    end
  endtask

  initial begin
    exp_data  = 32'h0;
    exp_err   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    rst = 1'b1;
    set_in($urandom, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 4'hF);
    step();
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", PC, 0);
    check("rst_wb", wb_en_out, 0);
    check("rst_ren", mem_r_en_out, 0);
    check("rst_res", alu_res_out, 0);
    check("rst_dest", dest_out, 0);
    check("rst_data", data_mem_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_err", mem_err, 0);

    do_instr(32'h100, 1, 0, 0, 32'h1234, 0, 4'd3, 0, 0, 0);
    do_instr(32'h104, 1, 1, 0, 32'd1032, 0, 4'd5, 2, 0, 32'hCAFEBABE);
    do_instr(32'h108, 0, 0, 1, 32'd1028, 32'h55, 4'd0, 0, 0, 0);
    do_instr(32'h10C, 1, 1, 1, 32'd0, 32'hA5A5_0001, 4'd7, TO, 0, 32'h1357_9BDF);
    do_instr(32'h110, 1, 1, 0, 32'd2000, 0, 4'd9, 0, 1, 0);
    do_instr(32'h114, 1, 0, 0, 32'hDEAD_0000, 0, 4'd1, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      logic r, w;
      logic [31:0] alu;
      kind = $urandom_range(0, 9);
      r = (kind >= 4 && kind <= 6) || kind == 9;
      w = (kind >= 7);
      alu = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 4095));
      do_instr($urandom, 1'($urandom), r, w, alu, $urandom, 4'($urandom),
               $urandom_range(0, TO), ($urandom_range(0, 9) == 0), $urandom);
    end

    set_in(32'h200, 1, 1, 0, 32'd1100, 0, 4'd2);
    mem_ready = 1'b0;
    step();
    step();
    check("midrst_busy_req", mem_req, 1);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    check("midrst_req", mem_req, 0);
    check("midrst_freeze", freeze, 0);
    check("midrst_err", mem_err, 0);
    check("midrst_data", data_mem_out, 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("late_ready_freeze", freeze, 0);
    step();
    mem_ready = 1'b0;
    check("late_ready_data", data_mem_out, 0);
    check("late_ready_req", mem_req, 0);
    check("late_ready_wb", wb_en_out, 0);
    check("late_ready_ren", mem_r_en_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
